// File: rtl/ofs_rst_seq_pkg.sv
// Shared types and default constants for the OFS reset sequencer.
package ofs_rst_seq_pkg;

  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_STABLE  = 3'd1,
    ST_RELEASE = 3'd2,
    ST_RUN     = 3'd3,
    ST_HOLD    = 3'd4
  } seq_state_e;

  localparam int unsigned DEF_NUM_DOMAINS        = 4;
  localparam int unsigned DEF_CNT_W              = 16;
  localparam int unsigned DEF_LOCK_STABLE_CYCLES = 1024;
  localparam int unsigned DEF_DOMAIN_DLY         = 64;
  localparam int unsigned DEF_HOLD_CYCLES        = 32;

  // Saturating increment for the 8-bit lock-loss event counter.
  function automatic logic [7:0] sat_inc8(input logic [7:0] v);
    return (v == 8'hFF) ? v : v + 8'd1;
  endfunction

endpackage

// File: rtl/fim_resync.sv
// Multi-stage flop synchronizer with asynchronous active-low clear.
module fim_resync #(
  parameter int unsigned WIDTH  = 1,
  parameter int unsigned STAGES = 2
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [WIDTH-1:0] d,
  output logic [WIDTH-1:0] q
);

  logic [STAGES-1:0][WIDTH-1:0] sync_q;

  // Shift the input through the synchronizer chain.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync_q <= '0;
    end else begin
      sync_q[0] <= d;
      for (int unsigned i = 1; i < STAGES; i++) begin
        sync_q[i] <= sync_q[i-1];
      end
    end
  end

  assign q = sync_q[STAGES-1];

endmodule

// File: rtl/ofs_rst_sequencer.sv
// Ordered per-domain reset release, qualified by a stable PLL lock.
module ofs_rst_sequencer
  import ofs_rst_seq_pkg::*;
#(
  parameter int unsigned                    NUM_DOMAINS        = DEF_NUM_DOMAINS,
  parameter int unsigned                    CNT_W              = DEF_CNT_W,
  parameter int unsigned                    LOCK_STABLE_CYCLES = DEF_LOCK_STABLE_CYCLES,
  parameter logic [NUM_DOMAINS*CNT_W-1:0]   DOMAIN_DLY         = {NUM_DOMAINS{CNT_W'(DEF_DOMAIN_DLY)}},
  parameter int unsigned                    HOLD_CYCLES        = DEF_HOLD_CYCLES
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   pll_locked,
  input  logic                   sw_rst_req,
  output logic [NUM_DOMAINS-1:0] domain_rst_n,
  output logic                   seq_done,
  output logic [2:0]             seq_state,
  output logic [7:0]             lock_loss_cnt
);

  localparam int unsigned      IDX_W       = (NUM_DOMAINS > 1) ? $clog2(NUM_DOMAINS) : 1;
  localparam logic [CNT_W-1:0] STABLE_LAST = CNT_W'((LOCK_STABLE_CYCLES > 0) ? LOCK_STABLE_CYCLES - 1 : 0);
  localparam logic [CNT_W-1:0] HOLD_LAST   = CNT_W'((HOLD_CYCLES > 0) ? HOLD_CYCLES - 1 : 0);
  localparam logic [IDX_W-1:0] IDX_LAST    = IDX_W'(NUM_DOMAINS - 1);

  logic                   lock;
  logic                   rst_ready;
  seq_state_e             state_q, state_d;
  logic [CNT_W-1:0]       cnt_q, cnt_d;
  logic [IDX_W-1:0]       idx_q, idx_d;
  logic [NUM_DOMAINS-1:0] dom_q, dom_d;
  logic                   done_q, done_d;
  logic [7:0]             loss_q, loss_d;
  logic [CNT_W-1:0]       dly_sel;
  logic [CNT_W-1:0]       dly_last;

  fim_resync #(
    .WIDTH  (1),
    .STAGES (2)
  ) u_lock_sync (
    .clk   (clk),
    .rst_n (rst_n),
    .d     (pll_locked),
    .q     (lock)
  );

  // Reset deassertion is re-timed so the FSM only leaves IDLE on a clean edge.
  fim_resync #(
    .WIDTH  (1),
    .STAGES (2)
  ) u_rst_sync (
    .clk   (clk),
    .rst_n (rst_n),
    .d     (1'b1),
    .q     (rst_ready)
  );

  // Select the release delay of the domain currently being sequenced; 0 acts as 1.
  always_comb begin
    dly_sel = '0;
    for (int unsigned i = 0; i < NUM_DOMAINS; i++) begin
      if (idx_q == IDX_W'(i)) dly_sel = DOMAIN_DLY[i*CNT_W +: CNT_W];
    end
    dly_last = (dly_sel == '0) ? '0 : dly_sel - 1'b1;
  end

  // Next-state logic; lock loss outranks a software request in the same cycle.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    idx_d   = idx_q;
    dom_d   = dom_q;
    done_d  = done_q;
    loss_d  = loss_q;

    if (state_q != ST_IDLE && !lock) begin
      state_d = ST_IDLE;
      cnt_d   = '0;
      idx_d   = '0;
      dom_d   = '0;
      done_d  = 1'b0;
      if (state_q != ST_STABLE) loss_d = sat_inc8(loss_q);
    end else if (sw_rst_req && (state_q == ST_RELEASE || state_q == ST_RUN)) begin
      state_d = ST_HOLD;
      cnt_d   = '0;
      idx_d   = '0;
      dom_d   = '0;
      done_d  = 1'b0;
    end else begin
      case (state_q)
        ST_IDLE: begin
          cnt_d  = '0;
          idx_d  = '0;
          dom_d  = '0;
          done_d = 1'b0;
          if (lock && rst_ready) state_d = ST_STABLE;
        end
        ST_STABLE: begin
          if (cnt_q == STABLE_LAST) begin
            state_d = ST_RELEASE;
            cnt_d   = '0;
            idx_d   = '0;
          end else begin
            cnt_d = cnt_q + 1'b1;
          end
        end
        ST_RELEASE: begin
          if (cnt_q == dly_last) begin
            cnt_d = '0;
            for (int unsigned i = 0; i < NUM_DOMAINS; i++) begin
              if (idx_q == IDX_W'(i)) dom_d[i] = 1'b1;
            end
            if (idx_q == IDX_LAST) begin
              state_d = ST_RUN;
              done_d  = 1'b1;
              idx_d   = '0;
            end else begin
              idx_d = idx_q + 1'b1;
            end
          end else begin
            cnt_d = cnt_q + 1'b1;
          end
        end
        ST_RUN: begin
          state_d = ST_RUN;
        end
        ST_HOLD: begin
          if (cnt_q == HOLD_LAST) begin
            state_d = ST_IDLE;
            cnt_d   = '0;
          end else begin
            cnt_d = cnt_q + 1'b1;
          end
        end
        default: begin
          state_d = ST_IDLE;
          cnt_d   = '0;
          idx_d   = '0;
          dom_d   = '0;
          done_d  = 1'b0;
        end
      endcase
    end
  end

  // State, counters and registered outputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
      cnt_q   <= '0;
      idx_q   <= '0;
      dom_q   <= '0;
      done_q  <= 1'b0;
      loss_q  <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      idx_q   <= idx_d;
      dom_q   <= dom_d;
      done_q  <= done_d;
      loss_q  <= loss_d;
    end
  end

  assign domain_rst_n  = dom_q;
  assign seq_done      = done_q;
  assign seq_state     = state_q;
  assign lock_loss_cnt = loss_q;

endmodule

// File: tb/tb_ofs_rst_sequencer.sv
// Self-checking bench: spec vector table, hand-written corner sequences and
// a randomized run scored against a timeline-based reference model.
module tb_ofs_rst_sequencer;

  localparam int N   = 4;
  localparam int LSC = 16;
  localparam int HC  = 4;

  logic         clk = 1'b0;
  logic         rst_n;
  logic         pll_locked;
  logic         sw_rst_req;
  logic [N-1:0] domain_rst_n;
  logic         seq_done;
  logic [2:0]   seq_state;
  logic [7:0]   lock_loss_cnt;

  int dly_tab [N] = '{8, 8, 8, 8};

  ofs_rst_sequencer #(
    .NUM_DOMAINS        (N),
    .CNT_W              (16),
    .LOCK_STABLE_CYCLES (LSC),
    .DOMAIN_DLY         ({16'd8, 16'd8, 16'd8, 16'd8}),
    .HOLD_CYCLES        (HC)
  ) dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .pll_locked    (pll_locked),
    .sw_rst_req    (sw_rst_req),
    .domain_rst_n  (domain_rst_n),
    .seq_done      (seq_done),
    .seq_state     (seq_state),
    .lock_loss_cnt (lock_loss_cnt)
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;
  int cyc   = 0;

  task automatic check(input string name, input logic [15:0] got, input logic [15:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s cyc=%0d got=%h exp=%h", name, cyc, got, exp);
    end
  endtask

  // Reference model: tracks when sequencing started (edge of STABLE entry) and
  // derives every output from elapsed time against cumulative release offsets.
  int   m_mode;   // 0 = not sequencing, 1 = sequencing since m_start, 2 = held since m_hold
  int   m_start;
  int   m_hold;
  int   m_llc;
  logic m_p1, m_p2, m_r1, m_r2;

  function automatic int rel_at(input int i);
    int acc = LSC;
    for (int j = 0; j <= i; j++) acc += (dly_tab[j] == 0) ? 1 : dly_tab[j];
    return acc;
  endfunction

  task automatic model_reset();
    m_mode = 0; m_start = 0; m_hold = 0; m_llc = 0;
    m_p1 = 1'b0; m_p2 = 1'b0; m_r1 = 1'b0; m_r2 = 1'b0;
  endtask

  task automatic model_step(input logic p, input logic s, input logic r);
    logic l;
    int   e;
    if (!r) begin
      model_reset();
      return;
    end
    l = m_p2 && m_r2;  // what the FSM sees: inputs sampled two edges ago
    case (m_mode)
      0: if (l) begin m_mode = 1; m_start = cyc; end
      1: begin
        e = cyc - m_start;
        if (!l) begin
          if (e > LSC && m_llc < 255) m_llc++;
          m_mode = 0;
        end else if (s && e > LSC) begin
          m_mode = 2; m_hold = cyc;
        end
      end
      default: begin
        if (!l) begin
          if (m_llc < 255) m_llc++;
          m_mode = 0;
        end else if (cyc - m_hold == HC) begin
          m_mode = 0;
        end
      end
    endcase
    m_p2 = m_p1; m_p1 = p;
    m_r2 = m_r1; m_r1 = r;
  endtask

  function automatic logic [15:0] model_out();
    logic [N-1:0] dom;
    logic         done;
    logic [2:0]   st;
    int           e;
    dom = '0; done = 1'b0; st = 3'd0;
    if (m_mode == 1) begin
      e = cyc - m_start;
      for (int i = 0; i < N; i++) dom[i] = (e >= rel_at(i));
      done = (e >= rel_at(N-1));
      st = (e < LSC) ? 3'd1 : (done ? 3'd3 : 3'd2);
    end else if (m_mode == 2) begin
      st = 3'd4;
    end
    return {dom, done, st, 8'(m_llc)};
  endfunction

  function automatic logic [15:0] dut_out();
    return {domain_rst_n, seq_done, seq_state, lock_loss_cnt};
  endfunction

  task automatic tick();
    logic p, s, r;
    @(posedge clk);
    p = pll_locked; s = sw_rst_req; r = rst_n;
    cyc++;
    model_step(p, s, r);
    #1;
    check("model", dut_out(), model_out());
  endtask

  task automatic run_to(input int c);
    while (cyc < c) tick();
  endtask

  task automatic do_reset();
    rst_n = 1'b0; pll_locked = 1'b0; sw_rst_req = 1'b0;
    #1;
    cyc = 0;
    model_reset();
    repeat (3) tick();
    rst_n = 1'b1;
  endtask

  typedef struct {
    bit         rst;
    int         cyc;
    logic       pll;
    logic [3:0] dom;
    logic       done;
    logic [2:0] st;
    logic [7:0] llc;
  } vec_t;

  vec_t vt[$];

  task automatic add(input bit r, input int c, input logic p, input logic [3:0] d,
                     input logic dn, input logic [2:0] s, input logic [7:0] l);
    vec_t v;
    v.rst = r; v.cyc = c; v.pll = p; v.dom = d; v.done = dn; v.st = s; v.llc = l;
    vt.push_back(v);
  endtask

  initial begin
    #5_000_000;
    $display("FAIL watchdog cyc=%0d got=timeout exp=finish", cyc);
    $fatal(1, "watchdog expired");
  end

  initial begin
    int n;
    rst_n = 1'b0; pll_locked = 1'b0; sw_rst_req = 1'b0;
    model_reset();

    // Nominal sequence: first edge sampling lock is cycle 100.
    add(1,  99, 0, 4'h0, 0, 3'd0, 8'd0);
    add(0, 101, 1, 4'h0, 0, 3'd0, 8'd0);
    add(0, 102, 1, 4'h0, 0, 3'd1, 8'd0);
    add(0, 117, 1, 4'h0, 0, 3'd1, 8'd0);
    add(0, 118, 1, 4'h0, 0, 3'd2, 8'd0);
    add(0, 125, 1, 4'h0, 0, 3'd2, 8'd0);
    add(0, 126, 1, 4'h1, 0, 3'd2, 8'd0);
    add(0, 133, 1, 4'h1, 0, 3'd2, 8'd0);
    add(0, 134, 1, 4'h3, 0, 3'd2, 8'd0);
    add(0, 142, 1, 4'h7, 0, 3'd2, 8'd0);
    add(0, 149, 1, 4'h7, 0, 3'd2, 8'd0);
    add(0, 150, 1, 4'hF, 1, 3'd3, 8'd0);
    // Lock glitch in STABLE: low on edges 110..112, restart from 115.
    add(1,  99, 0, 4'h0, 0, 3'd0, 8'd0);
    add(0, 109, 1, 4'h0, 0, 3'd1, 8'd0);
    add(0, 111, 0, 4'h0, 0, 3'd1, 8'd0);
    add(0, 112, 0, 4'h0, 0, 3'd0, 8'd0);
    add(0, 114, 1, 4'h0, 0, 3'd0, 8'd0);
    add(0, 115, 1, 4'h0, 0, 3'd1, 8'd0);
    add(0, 138, 1, 4'h0, 0, 3'd2, 8'd0);
    add(0, 139, 1, 4'h1, 0, 3'd2, 8'd0);
    add(0, 163, 1, 4'hF, 1, 3'd3, 8'd0);

    for (int i = 0; i < vt.size(); i++) begin
      if (vt[i].rst) do_reset();
      pll_locked = vt[i].pll;
      run_to(vt[i].cyc);
      check($sformatf("vec%0d", i), dut_out(),
            {vt[i].dom, vt[i].done, vt[i].st, vt[i].llc});
    end

    // Lock loss in RUN: lock first sampled low at edge 200.
    run_to(199);
    pll_locked = 1'b0;
    run_to(201);
    check("run_before_loss", 16'(domain_rst_n), 16'hF);
    run_to(203);
    check("run_loss", dut_out(), {4'h0, 1'b0, 3'd0, 8'd1});

    // Software reset in RUN; a second request during HOLD must be ignored.
    pll_locked = 1'b1;
    run_to(259);
    check("sw_pre_run", dut_out(), {4'hF, 1'b1, 3'd3, 8'd1});
    sw_rst_req = 1'b1; tick(); sw_rst_req = 1'b0;
    check("sw_hold_entry", dut_out(), {4'h0, 1'b0, 3'd4, 8'd1});
    sw_rst_req = 1'b1; tick(); sw_rst_req = 1'b0;
    run_to(263);
    check("hold_last", 16'(seq_state), 16'd4);
    tick();
    check("hold_to_idle", 16'(seq_state), 16'd0);
    tick();
    check("idle_to_stable", 16'(seq_state), 16'd1);
    // A request in STABLE is ignored.
    run_to(269);
    sw_rst_req = 1'b1; tick(); sw_rst_req = 1'b0;
    check("sw_in_stable", 16'(seq_state), 16'd1);
    // STABLE entered at 265 after one IDLE cycle; domain 0 follows 16+8 cycles later.
    run_to(288);
    check("reseq_dom0_early", 16'(domain_rst_n), 16'h0);
    tick();
    check("reseq_dom0", 16'(domain_rst_n), 16'h1);

    // Lock loss and software request on the same edge (322).
    run_to(319);
    check("simul_pre_run", 16'(seq_state), 16'd3);
    pll_locked = 1'b0;
    run_to(321);
    sw_rst_req = 1'b1; tick(); sw_rst_req = 1'b0;
    check("simul_state", 16'(seq_state), 16'd0);
    check("simul_llc", 16'(lock_loss_cnt), 16'd2);

    // Randomized lock drops and software requests against the model.
    begin
      int low_left = 0;
      for (int i = 0; i < 3000; i++) begin
        if (low_left > 0) begin
          pll_locked = 1'b0;
          low_left--;
        end else begin
          pll_locked = 1'b1;
          if ($urandom_range(0, 149) == 0) low_left = int'($urandom_range(1, 8));
        end
        sw_rst_req = ($urandom_range(0, 39) == 0);
        tick();
      end
      sw_rst_req = 1'b0;
    end

    // 300 lock-loss events out of RELEASE saturate the counter.
    pll_locked = 1'b0;
    repeat (4) tick();
    for (int i = 0; i < 300; i++) begin
      pll_locked = 1'b1;
      repeat (21) tick();
      pll_locked = 1'b0;
      repeat (4) tick();
    end
    check("llc_saturated", 16'(lock_loss_cnt), 16'd255);

    // Asynchronous reset mid-RELEASE.
    pll_locked = 1'b1;
    n = 0;
    while (!domain_rst_n[0] && n < 80) begin
      tick();
      n++;
    end
    check("dom0_before_async", 16'(domain_rst_n[0]), 16'd1);
    tick();
    check("release_before_async", 16'(seq_state), 16'd2);
    #3;
    rst_n = 1'b0;
    #1;
    check("async_rst", dut_out(), 16'h0000);
    repeat (2) tick();
    rst_n = 1'b1;
    n = 0;
    while (!domain_rst_n[0] && n < 60) begin
      tick();
      n++;
    end
    check("reseq_after_rst", 16'(n), 16'd27);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
